// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns ({a..g}, bit6=a), error code and FSM states for seg7_scan_reader.
package seg7_pkg;
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;
    localparam logic [3:0] ERR_CODE = 4'hF;
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
endpackage

// File: rtl/seg7_pat_dec.sv
// seg7_pat_dec: 7-segment pattern to {err,code}; hex letters A-F decode only when SEG7_HEX_EN is defined.
module seg7_pat_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);
    always_comb begin
        {err, code} = {1'b1, ERR_CODE};
        case (seg)
            SEG_0: {err, code} = {1'b0, 4'h0};
            SEG_1: {err, code} = {1'b0, 4'h1};
            SEG_2: {err, code} = {1'b0, 4'h2};
            SEG_3: {err, code} = {1'b0, 4'h3};
            SEG_4: {err, code} = {1'b0, 4'h4};
            SEG_5: {err, code} = {1'b0, 4'h5};
            SEG_6: {err, code} = {1'b0, 4'h6};
            SEG_7: {err, code} = {1'b0, 4'h7};
            SEG_8: {err, code} = {1'b0, 4'h8};
            SEG_9: {err, code} = {1'b0, 4'h9};
`ifdef SEG7_HEX_EN
            SEG_A: {err, code} = {1'b0, 4'hA};
            SEG_B: {err, code} = {1'b0, 4'hB};
            SEG_C: {err, code} = {1'b0, 4'hC};
            SEG_D: {err, code} = {1'b0, 4'hD};
            SEG_E: {err, code} = {1'b0, 4'hE};
            SEG_F: {err, code} = {1'b0, 4'hF};
`else
`endif
            default: {err, code} = {1'b1, ERR_CODE};
        endcase
    end
endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers digit codes from a multiplexed 7-segment bus and publishes full frames.
// Hex letter decoding is enabled by defining SEG7_HEX_EN.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   an_in,
    output logic [4*NDIG-1:0] frame_data,
    output logic              frame_err,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              overrun
);
    localparam int IW = $clog2(NDIG);
    localparam logic [7:0] CAP_CNT = 8'(STABLE - 1);

    state_t            state, nxt;
    logic [NDIG-1:0]   samp_an, seen;
    logic [6:0]        samp_seg;
    logic [7:0]        cnt;
    logic [IW-1:0]     idx;
    logic              an_ok, cap, done, dig_err, fr_err;
    logic [3:0]        dig_code;
    logic [4:0]        dig [NDIG];
    logic [4*NDIG-1:0] fr_data;

    seg7_pat_dec u_dec (.seg(samp_seg), .code(dig_code), .err(dig_err));

    assign an_ok = $countones(~samp_an) == 1;
    assign done  = &seen;

    always_comb begin
        idx     = '0;
        fr_err  = 1'b0;
        fr_data = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!samp_an[i]) idx = IW'(i);
            fr_data[4*i +: 4] = dig[i][3:0];
            fr_err = fr_err | dig[i][4];
        end
    end

    // cnt==0 means the registered sample just changed, which ends a HOLD window
    always_comb begin
        nxt = state;
        cap = 1'b0;
        case (state)
            IDLE:    nxt = an_ok ? SETTLE : IDLE;
            SETTLE: begin
                cap = an_ok && cnt == CAP_CNT;
                nxt = !an_ok ? IDLE : (cap ? HOLD : SETTLE);
            end
            HOLD:    nxt = cnt != 8'd0 ? HOLD : (an_ok ? SETTLE : IDLE);
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            samp_an     <= '0;
            samp_seg    <= '0;
            cnt         <= '0;
            seen        <= '0;
            frame_data  <= '0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < NDIG; i++) dig[i] <= '0;
        end else begin
            state    <= nxt;
            samp_an  <= an_in;
            samp_seg <= seg_in;
            cnt      <= ({an_in, seg_in} != {samp_an, samp_seg}) ? 8'd0 : (&cnt ? cnt : cnt + 8'd1);
            seen     <= (done ? '0 : seen) | (cap ? NDIG'(1) << idx : '0);
            if (cap) dig[idx] <= {dig_err, dig_code};
            if (done) begin
                frame_data  <= fr_data;
                frame_err   <= fr_err;
                frame_valid <= 1'b1;
                overrun     <= overrun | (frame_valid & ~frame_ready);
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: randomized bus stimulus against a segment-run reference model of the scan reader.
module tb_seg7_scan_reader;
    localparam int NDIG   = 4;
    localparam int STABLE = 4;
`ifdef SEG7_HEX_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif
    localparam logic [6:0] PAT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic              clk = 1'b0, rst_n = 1'b0, frame_ready = 1'b0;
    logic [6:0]        seg_in = '0;
    logic [NDIG-1:0]   an_in = '1;
    logic [4*NDIG-1:0] frame_data;
    logic              frame_err, frame_valid, overrun;

    int n_chk = 0, n_err = 0;
    bit mon_en = 1'b0;
    logic [4*NDIG:0]   exp_q[$], got_q[$];
    logic [4:0]        m_dig [NDIG];
    logic [NDIG-1:0]   m_seen;
    logic [NDIG+6:0]   m_prev;
    int                m_run;
    logic [4*NDIG:0]   m_last;

    seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
        .frame_data(frame_data), .frame_err(frame_err), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .overrun(overrun));

    always #5 clk = ~clk;

    always @(negedge clk) if (mon_en && frame_valid && frame_ready) got_q.push_back({frame_err, frame_data});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_dec(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (s == PAT[i] && (i < 10 || HEX)) return {1'b0, 4'(i)};
        return 5'h1F;
    endfunction

    // a digit is captured once per run of identical bus values lasting STABLE cycles
    task automatic hold(input logic [NDIG-1:0] a, input logic [6:0] s, input int n);
        int old, k;
        logic [4*NDIG:0] f;
        an_in  = a;
        seg_in = s;
        old    = ({a, s} == m_prev) ? m_run : 0;
        m_prev = {a, s};
        m_run  = old + n;
        if ($countones(~a) == 1 && old < STABLE && m_run >= STABLE) begin
            k = 0;
            for (int i = 0; i < NDIG; i++) if (!a[i]) k = i;
            m_dig[k]  = ref_dec(s);
            m_seen[k] = 1'b1;
            if (&m_seen) begin
                f = '0;
                for (int i = 0; i < NDIG; i++) begin
                    f[4*i +: 4] = m_dig[i][3:0];
                    f[4*NDIG]   = f[4*NDIG] | m_dig[i][4];
                end
                exp_q.push_back(f);
                m_last = f;
                m_seen = '0;
            end
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n  = 1'b0;
        an_in  = '1;
        seg_in = '0;
        repeat (n) @(negedge clk);
        rst_n  = 1'b1;
        m_seen = '0;
        m_prev = '0;
        m_run  = 0;
        m_last = '0;
        for (int i = 0; i < NDIG; i++) m_dig[i] = '0;
    endtask

    task automatic scan(input logic [7*NDIG-1:0] p, input int n);
        for (int i = 0; i < NDIG; i++) hold(~(NDIG'(1) << i), p[7*i +: 7], n);
        hold('1, 7'b0, 6);
    endtask

    task automatic cmp_q(input string tag);
        check({tag, "_frames"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_first(input string tag, input logic [4*NDIG:0] exp);
        check(tag, got_q.size() > 0 ? 64'(got_q[0]) : 64'hDEAD, 64'(exp));
    endtask

    initial begin
        do_reset(3);
        hold('1, 7'b0, 20);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_data", 64'(frame_data), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);

        frame_ready = 1'b1;
        mon_en      = 1'b1;
        scan({7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001}, 8);
        check_first("scan_0123", {1'b0, 16'h0123});
        cmp_q("scan");

        hold(4'b1110, 7'b1111111, 3);
        hold(4'b1110, 7'b1011011, 6);
        for (int i = 1; i < NDIG; i++) hold(~(NDIG'(1) << i), PAT[6 + i], 8);
        hold('1, 7'b0, 6);
        check_first("glitch", {1'b0, 16'h9875});
        cmp_q("glitch");

        scan({PAT[7], 7'b0000001, PAT[6], PAT[4]}, 5);
        check_first("invalid", {1'b1, 16'h7F64});
        cmp_q("invalid");
        scan({PAT[7], 7'b1110111, PAT[6], PAT[4]}, 5);
        check_first("hex_a", HEX ? {1'b0, 16'h7A64} : {1'b1, 16'h7F64});
        cmp_q("hex");

        for (int j = 0; j < 400; j++) begin
            int r;
            logic [NDIG-1:0] a;
            logic [6:0] s;
            r = $urandom_range(0, 9);
            a = ~(NDIG'(1) << $urandom_range(0, NDIG - 1));
            s = PAT[$urandom_range(0, 15)];
            if (r == 0) s = 7'($urandom);
            if (r == 1) a = '1;
            if (r == 2) a = a & ~(NDIG'(1) << $urandom_range(0, NDIG - 1));
            hold(a, s, $urandom_range(1, STABLE + 4));
        end
        hold('1, 7'b0, 6);
        cmp_q("rand");
        check("rand_overrun", 64'(overrun), 64'd0);

        mon_en      = 1'b0;
        frame_ready = 1'b0;
        scan({PAT[1], PAT[2], PAT[3], PAT[4]}, 6);
        scan({PAT[9], PAT[8], PAT[7], PAT[6]}, 6);
        exp_q.delete();
        check("bp_valid", 64'(frame_valid), 64'd1);
        check("bp_overrun", 64'(overrun), 64'd1);
        check("bp_data", 64'({frame_err, frame_data}), 64'(m_last));
        check("bp_second", 64'(frame_data), 64'h9876);
        frame_ready = 1'b1;
        @(negedge clk);
        check("bp_drop", 64'(frame_valid), 64'd0);
        check("bp_sticky", 64'(overrun), 64'd1);

        mon_en = 1'b1;
        hold(4'b1110, PAT[8], 6);
        hold(4'b1101, PAT[8], 6);
        do_reset(1);
        check("rst_mid_overrun", 64'(overrun), 64'd0);
        hold(4'b1011, PAT[4], 6);
        hold(4'b0111, PAT[2], 6);
        hold('1, 7'b0, 6);
        cmp_q("rst_part");
        hold(4'b1110, PAT[3], 6);
        hold(4'b1101, PAT[1], 6);
        hold('1, 7'b0, 6);
        check_first("rst_full", {1'b0, 16'h2413});
        cmp_q("rst_full");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Reverse of the BCD-to-7-segment decoder path.
- Watches a multiplexed 7-segment display bus (segment lines plus active-low digit strobes) and recovers the 4-bit code of each digit.
- Publishes a complete NDIG-digit frame through a valid/ready handshake.
- Used as a loop-back checker and scoreboard source behind the display driver.

Parameters:
- NDIG, 4, number of multiplexed digits (2..8).
- STABLE, 4, consecutive identical samples required before a digit is captured (2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- seg_in  in  7  segment lines {a,b,c,d,e,f,g}, bit6=a, active-high (1 = lit).
- an_in  in  NDIG  digit strobes, active-low, one-hot-zero expected.
- frame_data  out  4*NDIG  digit codes, digit i in bits [4i+3:4i].
- frame_err  out  1  at least one digit in the frame had an unknown pattern.
- frame_valid  out  1  frame available.
- frame_ready  in  1  consumer accepts frame.
- overrun  out  1  sticky: a completed frame overwrote an unaccepted one.

Behaviour:
- Reset (rst_n=0 at a clk edge), all outputs and state cleared:
  - frame_data=0, frame_err=0, frame_valid=0, overrun=0.
  - seen mask 0, stability counter 0, FSM to IDLE.
  - Applies mid-frame; partial digits are discarded.
- Input sampling: {an_in,seg_in} registered every cycle.
  - Counter increments, saturating, while sample equals previous sample.
  - Counter clears to 0 on any difference.
- FSM:
  - IDLE: an sample all-ones (blank) or more than one bit low. No capture. Go to SETTLE when an is exactly one-hot-low.
  - SETTLE: counting. When counter reaches STABLE-1 (STABLE equal samples), write code and error bit for index idx, set seen[idx], go to HOLD. Any change before that restarts counting (stay SETTLE, or IDLE if an becomes invalid).
  - HOLD: one capture per stable window. On any sample change go to SETTLE or IDLE per the rules above.
- Latency: a pattern held from input edge k is captured into the digit register at edge k+STABLE.
- Code table (bits abcdefg → code), all others give code 4'hF with err=1:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9
- Re-capturing an already-seen digit overwrites it (last value wins).
- Frame completion, the cycle after seen becomes all-ones:
  - frame_data and frame_err loaded from digit registers.
  - frame_valid=1; seen cleared.
- Handshake:
  - frame_valid holds until a cycle with frame_ready=1; clears on the next edge.
  - Completion while frame_valid=1 and frame_ready=0: new frame overwrites data, valid stays 1, overrun set (cleared only by reset).
  - Completion in the same cycle as frame_ready=1: new frame loaded, valid stays 1, no overrun.

Optional Feature:
- Macro: SEG7_HEX_EN.
- Defined: additional patterns decode with err=0:
  - 1110111→A, 0011111→B, 1001110→C
  - 0111101→D, 1001111→E, 1000111→F
- Not defined: those patterns give code F with err=1.
- Digits 0-9 behave identically either way.

Decomposition:
- Package seg7_pkg: segment pattern constants SEG_0..SEG_9, SEG_A..SEG_F, ERR_CODE=4'hF, FSM state encoding (IDLE/SETTLE/HOLD).
- Sub-module seg7_pat_dec: combinational 7-bit pattern to {err,code[3:0]}, contains the SEG7_HEX_EN table.
- Top holds sampler, counter, FSM, digit registers, frame and handshake logic.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, release, an_in=4'b1111 for 20 cycles → frame_valid=0, overrun=0, frame_data=0.
- Normal scan: strobe an=1110,1101,1011,0111 with 1111001,1101101,0110000,1111110, each 8 cycles, frame_ready=1 → one frame_valid pulse, frame_data=16'h0123, frame_err=0.
- Glitch filter (STABLE=4): present digit 0 with pattern 1111111 for 3 cycles then 1011011 for 6 → only 5 captured; frame reports 5 at that digit.
- Invalid pattern: 0000001 on digit 2 within an otherwise valid scan → digit 2 = F, frame_err=1. With SEG7_HEX_EN, 1110111 → A and err=0; without it, F and err=1.
- Backpressure: frame_ready=0 across two complete scans → frame_valid stays 1, overrun=1, frame_data = second frame. Then ready=1 → valid drops next edge.
- Reset mid-scan: after 2 of 4 digits captured, pulse rst_n low 1 cycle, then a full scan → exactly one frame, containing only post-reset digits.
